// File: rtl/pe_array_sequencer_pkg.sv
// pe_seq_pkg: shared state encoding, lane width and drain-length helper for pe_array_sequencer.
package pe_seq_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    localparam int DW = 8;
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction
endpackage

// File: rtl/pe_array_sequencer_skew_line.sv
// skew_line: DEPTH-stage operand delay with valid tracking; data reads 0 whenever its valid is low.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          valid,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);
    if (DEPTH == 0) begin : g_comb
        logic unused;
        assign unused = clk ^ rst ^ flush;
        assign q = valid ? data : '0;
    end else begin : g_reg
        logic [DEPTH-1:0] v;
        logic [DW-1:0] d [DEPTH];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= '0;
                for (int k = 0; k < DEPTH; k++) d[k] <= '0;
            end else if (flush) begin
                v <= '0;
                for (int k = 0; k < DEPTH; k++) d[k] <= '0;
            end else begin
                v[0] <= valid;
                d[0] <= valid ? data : '0;
                for (int k = 1; k < DEPTH; k++) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
        end
        assign q = v[DEPTH-1] ? d[DEPTH-1] : '0;
    end
endmodule

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: drives an N x N output-stationary MAC array through one N x K by K x N product.
// Optional PE_SEQ_ABORT_EN adds an abort input that cancels a running job without a done pulse.
module pe_array_sequencer
    import pe_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int DW = pe_seq_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
`ifdef PE_SEQ_ABORT_EN
    input  logic            abort,
`endif
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic            busy,
    output logic            rd_en,
    output logic [KW-1:0]   rd_addr,
    input  logic [N*DW-1:0] a_rd_data,
    input  logic [N*DW-1:0] b_rd_data,
    output logic [N*DW-1:0] a_feed,
    output logic [N*DW-1:0] b_feed,
    output logic            acc_clr,
    output logic            done
);
    localparam logic [KW-1:0] DRAIN_LAST = KW'(drain_len(N) - 1);

    state_t st, nxt;
    logic [KW-1:0] kl, cnt;
    logic vld, abt;

`ifdef PE_SEQ_ABORT_EN
    assign abt = abort && (st == CLEAR || st == FEED || st == DRAIN);
`else
    assign abt = 1'b0;
`endif

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start ? CLEAR : IDLE;
            CLEAR:   nxt = (kl == '0) ? DONE : FEED;
            FEED:    nxt = (cnt == kl - 1'b1) ? DRAIN : FEED;
            DRAIN:   nxt = (cnt == DRAIN_LAST) ? DONE : DRAIN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abt) nxt = IDLE;
        busy    = st != IDLE;
        rd_en   = st == FEED && !abt;
        rd_addr = (st == FEED) ? cnt : '0;
        acc_clr = st == CLEAR;
        done    = st == DONE;
    end

    // cnt restarts on every state change, so it serves both FEED addressing and DRAIN timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= IDLE;
            kl  <= '0;
            cnt <= '0;
            vld <= 1'b0;
        end else begin
            st  <= nxt;
            kl  <= (st == IDLE && start) ? k_len : kl;
            cnt <= (nxt != st) ? '0 : cnt + 1'b1;
            vld <= rd_en;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH(i), .DW(DW)) u_a (
            .clk(clk), .rst(rst), .flush(abt), .valid(vld),
            .data(a_rd_data[i*DW +: DW]), .q(a_feed[i*DW +: DW])
        );
        skew_line #(.DEPTH(i), .DW(DW)) u_b (
            .clk(clk), .rst(rst), .flush(abt), .valid(vld),
            .data(b_rd_data[i*DW +: DW]), .q(b_feed[i*DW +: DW])
        );
    end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer: scoreboard bench with operand-buffer and PE-array models around the sequencer.
module tb_pe_array_sequencer;
    localparam int N = 4, KW = 8, DW = 8;
    typedef bit [7:0] mat_t [N*N];
    typedef struct {int t; mat_t m;} res_t;
    typedef struct {int t; int k;} job_t;

    logic clk = 0, rst = 1, start = 0;
    logic [KW-1:0] k_len = '0;
    logic busy, rd_en, acc_clr, done;
    logic [KW-1:0] rd_addr;
    logic [N*DW-1:0] a_rd_data = '0, b_rd_data = '0, a_feed, b_feed;

    pe_array_sequencer #(.N(N), .KW(KW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .a_feed(a_feed), .b_feed(b_feed), .acc_clr(acc_clr), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0, total = 0, bad = 0;
    bit [7:0] am [N][256];
    bit [7:0] bm [256][N];
    bit [7:0] pa [N][N], pb [N][N], acc [N][N];
    bit [7:0] ai, bi;
    job_t jq[$];
    res_t sq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // operand buffers: one-cycle registered read
    always @(posedge clk) if (rd_en)
        for (int i = 0; i < N; i++) begin
            a_rd_data[i*DW +: DW] <= am[i][rd_addr];
            b_rd_data[i*DW +: DW] <= bm[rd_addr][i];
        end

    // output-stationary MAC array: a flows east, b flows south
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (j == 0) ai = a_feed[i*DW +: DW]; else ai = pa[i][j-1];
                if (i == 0) bi = b_feed[j*DW +: DW]; else bi = pb[i-1][j];
                pa[i][j] <= ai;
                pb[i][j] <= bi;
                acc[i][j] <= acc_clr ? 8'h00 : acc[i][j] + ai * bi;
            end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int tdone(input int t, input int k);
        return (k == 0) ? t + 2 : t + k + 2 * N + 1;
    endfunction

    // cycle-by-cycle control and feed monitor
    always @(negedge clk) if (!rst) begin
        logic [N*DW-1:0] ea, eb;
        logic er, ec, eby, ed;
        logic [KW-1:0] eadr;
        int t, k, d;
        ea = '0; eb = '0; er = 0; ec = 0; eby = 0; ed = 0; eadr = '0;
        foreach (jq[q]) begin
            t = jq[q].t;
            k = jq[q].k;
            if (cyc == t + 1) ec = 1;
            if (cyc >= t + 1 && cyc <= tdone(t, k)) eby = 1;
            if (cyc == tdone(t, k)) ed = 1;
            if (cyc >= t + 2 && cyc <= t + k + 1) begin
                er = 1;
                eadr = KW'(cyc - t - 2);
            end
            for (int i = 0; i < N; i++) begin
                d = cyc - t - 3 - i;
                if (d >= 0 && d < k) begin
                    ea[i*DW +: DW] = am[i][d];
                    eb[i*DW +: DW] = bm[d][i];
                end
            end
        end
        chk("busy", busy, eby);
        chk("rd_en", rd_en, er);
        chk("rd_addr", rd_addr, eadr);
        chk("acc_clr", acc_clr, ec);
        chk("done", done, ed);
        chk("a_feed", a_feed, ea);
        chk("b_feed", b_feed, eb);
    end

    // result scoreboard: pops on every done pulse
    always @(negedge clk) if (!rst && done) begin
        res_t r;
        if (sq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got pulse want none at cycle %0d", cyc);
        end else begin
            r = sq.pop_front();
            chk("done_cycle", cyc, r.t);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    chk($sformatf("pe%0d%0d", i, j), acc[i][j], r.m[i*N+j]);
        end
    end

    task automatic start_job(input int k, input mat_t m, input bit hold);
        @(negedge clk);
        for (int n = 0; busy && n < 200; n++) @(negedge clk);
        start = 1;
        k_len = KW'(k);
        jq.push_back('{cyc, k});
        sq.push_back('{tdone(cyc, k), m});
        @(posedge clk);
        #1 if (!hold) start = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sq.size() > 0) && n < 500);
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL timeout: got busy=%0b pending=%0d want idle", busy, sq.size());
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_acc_clr"}, acc_clr, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_a_feed"}, a_feed, 0);
        chk({tag, "_b_feed"}, b_feed, 0);
    endtask

    task automatic load_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = (i == k) ? 8'd1 : 8'd0;
                bm[k][i] = 8'(4 * k + i + 1);
            end
    endtask

    task automatic load_product();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) begin
                am[i][k] = 8'(i + k + 1);
                bm[k][i] = 8'((k + 1) * (i + 1));
            end
    endtask

    mat_t m_ident = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    mat_t m_wrap  = '{default: 8'h63};
    mat_t m_prod  = '{5, 10, 15, 20, 8, 16, 24, 32, 11, 22, 33, 44, 14, 28, 42, 56};
    mat_t m_zero  = '{default: 8'h00};
    int t1, t2;

    initial begin
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 0;

        load_identity();
        start_job(4, m_ident, 0);
        wait_idle();

        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) begin
                am[i][k] = 8'h11;
                bm[k][i] = 8'h11;
            end
        start_job(3, m_wrap, 0);
        wait_idle();

        load_product();
        start_job(2, m_prod, 0);
        wait_idle();

        start_job(0, m_zero, 0);
        wait_idle();

        start_job(5, m_zero, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1;
        jq.delete();
        sq.delete();
        #1 check_quiet("midreset");
        repeat (2) @(negedge clk);
        rst = 0;

        load_identity();
        start_job(4, m_ident, 0);
        wait_idle();

        load_product();
        start_job(2, m_prod, 1);
        t1 = jq[jq.size()-1].t;
        t2 = t1 + 2 + 2 * N + 2;
        jq.push_back('{t2, 2});
        sq.push_back('{tdone(t2, 2), m_prod});
        while (cyc <= t2) @(negedge clk);
        start = 0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Sequences an N x N output-stationary systolic array of 8-bit multiply-accumulate PEs through one matrix product (N x K times K x N).
- Fetches one operand column and one operand row per cycle from the A/B operand buffers.
- Skews those operands onto the array's west (a) and north (b) edges, clears the PE accumulators before each job, and waits for the wavefront to drain.
- Pulses done when every PE holds its final 8-bit (mod 256) dot product.

Parameters:
- N, 4, array dimension (rows = columns = lanes), 2..8
- KW, 8, width of k_len and rd_addr
- DW, 8, operand lane width (matches PE a/b width)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  KW  inner dimension K; captured with start
- busy  out  1  high in all states except IDLE
- rd_en  out  1  operand-buffer read strobe (A and B buffers read in parallel)
- rd_addr  out  KW  buffer address k, 0..K-1
- a_rd_data  in  N*DW  A column k, lane i = row i; valid 1 cycle after rd_en
- b_rd_data  in  N*DW  B row k, lane j = column j; valid 1 cycle after rd_en
- a_feed  out  N*DW  west-edge operands, lane i drives PE(i,0).a
- b_feed  out  N*DW  north-edge operands, lane j drives PE(0,j).b
- acc_clr  out  1  synchronous clear to all PE accumulators
- done  out  1  one-cycle pulse: results stable

Behaviour:
- Reset: state=IDLE; busy, rd_en, acc_clr, done = 0; rd_addr = 0; a_feed, b_feed and all skew registers = 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR when start=1. Latch K=k_len.
- CLEAR: acc_clr=1 for exactly 1 cycle.
  - K=0: go to DONE (no reads).
  - K>0: go to FEED.
- FEED: K cycles; rd_en=1; rd_addr = 0,1,...,K-1. After the last read, go to DRAIN.
- DRAIN: fixed 2N-1 cycles (1 read latency + (N-1) skew + (N-1) propagation), counted by an internal counter. Then go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. start in this cycle is ignored.
- Skew:
  - Returned lane i (a) / lane j (b) passes through i / j registers before reaching a_feed / b_feed. Lane 0 is combinational from read data, gated by the valid pipeline.
  - Lanes carry 0 whenever no valid operand is present, so PE products outside the window are 0 and accumulation is unaffected.
- Latency: if start is accepted in cycle t:
  - acc_clr in t+1
  - reads in t+2..t+K+1
  - last MAC at PE(N-1,N-1) in t+K+2N
  - done in t+K+2N+1 (K>0)
  - done in t+2 (K=0)
- Arithmetic: the sequencer does no arithmetic on data; PE sums wrap mod 256. Counters are KW bits. K up to 2^KW-1 is legal.
- start while busy: ignored, no queuing.
- Reset mid-job: async return to reset values; PE contents undefined until the next CLEAR.

Optional Feature:
- Macro PE_SEQ_ABORT_EN adds input abort (1 bit).
- With the macro: abort=1 in CLEAR/FEED/DRAIN forces IDLE next cycle, deasserts rd_en, zeros all skew registers and a_feed/b_feed, and does not pulse done. abort in IDLE/DONE has no effect.
- Without the macro: no port; jobs always run to done.

Decomposition:
- Package pe_seq_pkg holds:
  - state enum (IDLE, CLEAR, FEED, DRAIN, DONE)
  - DW=8 constant
  - drain-length function f(N)=2N-1
- Sub-module skew_line (param DEPTH, DW): DEPTH-stage register chain with valid, async reset to 0, and a synchronous flush input for abort.
- Instantiate 2N skew_line (DEPTH=lane index).

Test Plan:
- Reset/idle: assert rst mid-FEED with N=4, K=5 -> all outputs 0 same cycle; after release, busy=0 and start accepted normally.
- Identity product: N=4, K=4, A=I, B=B0 (values 1..16) -> done at t+13; PE(i,j) holds B0[i][j]. Check feed lanes are skewed by i/j cycles and zero elsewhere.
- Wrap: N=2, K=3, all A=B=0x10 -> each PE = 3*256 mod 256 = 0x00; done at t+8.
- K=0: start with k_len=0 -> acc_clr at t+1, no rd_en, done at t+2; PE values 0.
- Back-to-back: start held high across DONE -> second job accepted in the IDLE cycle after done, not in DONE; second acc_clr clears the first job's results.
- PE_SEQ_ABORT_EN: abort in cycle 3 of FEED (N=4, K=8) -> IDLE next cycle, no done, feeds 0; next job with K=2 completes correctly.
